// File: rtl/mux_2to1_arbiter.sv
// rtl/mux_2to1_arbiter.sv - two-source round-robin arbiter feeding a one-entry output register
//
// Mux_2to1
//   a, b  : data inputs (a selected when sel=0, b when sel=1)
//   sel   : select
//   y     : selected data
//
// mux_2to1_arbiter
//   clk_i           : clock, all state updates on the rising edge
//   rst_i           : synchronous active-low reset
//   req0_valid_i    : source 0 has data
//   req0_data_i     : source 0 data (mux input a)
//   req0_ready_o    : source 0 transfer accepted this cycle
//   req1_valid_i    : source 1 has data
//   req1_data_i     : source 1 data (mux input b)
//   req1_ready_o    : source 1 transfer accepted this cycle
//   out_valid_o     : output register holds data
//   out_data_o      : registered data
//   out_src_o       : source index of the registered data
//   out_ready_i     : sink accepts the output this cycle

module Mux_2to1 #(
    parameter int size = 15
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            sel,
    output logic [size-1:0] y
);

    always_comb begin
        y = sel ? b : a;
    end

endmodule

module mux_2to1_arbiter #(
    parameter int size = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_valid_i,
    input  logic [size-1:0] req0_data_i,
    output logic            req0_ready_o,
    input  logic            req1_valid_i,
    input  logic [size-1:0] req1_data_i,
    output logic            req1_ready_o,
    output logic            out_valid_o,
    output logic [size-1:0] out_data_o,
    output logic            out_src_o,
    input  logic            out_ready_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [size-1:0]   data_q,  data_d;
    logic              src_q,   src_d;
    logic              last_q,  last_d;

    logic              grant;
    logic              drain;
    logic              can_load;
    logic              load;
    logic [size-1:0]   mux_y;

    // Grant: a lone requester always wins; under contention the source that
    // was not served last wins. With no request the select idles at 0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    Mux_2to1 #(.size(size)) u_mux (
        .a   (req0_data_i),
        .b   (req1_data_i),
        .sel (grant),
        .y   (mux_y)
    );

    // A drain frees the slot in the same cycle, so a new entry can replace the
    // outgoing one and sustain one transfer per cycle.
    always_comb begin
        drain    = (state_q == FULL) && out_ready_i;
        can_load = (state_q == EMPTY) || drain;
        req0_ready_o = can_load && req0_valid_i && !grant;
        req1_ready_o = can_load && req1_valid_i &&  grant;
        load     = req0_ready_o || req1_ready_o;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath next values: contents and priority pointer only move on a
    // load, so a drain leaves stale data in place and idle cycles keep priority.
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        last_d = last_q;
        if (load) begin
            data_d = mux_y;
            src_d  = grant;
            last_d = grant;
        end
    end

    // Output logic
    always_comb begin
        out_valid_o = (state_q == FULL);
        out_data_o  = data_q;
        out_src_o   = src_q;
    end

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// tb/tb_mux_2to1_arbiter.sv - self-checking bench for mux_2to1_arbiter

module tb_mux_2to1_arbiter;

    localparam int W = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_valid_i;
    logic [W-1:0]  req0_data_i;
    logic          req0_ready_o;
    logic          req1_valid_i;
    logic [W-1:0]  req1_data_i;
    logic          req1_ready_o;
    logic          out_valid_o;
    logic [W-1:0]  out_data_o;
    logic          out_src_o;
    logic          out_ready_i;

    mux_2to1_arbiter #(.size(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_src_o    (out_src_o),
        .out_ready_i  (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Reference model: the contents of the output slot and who was served last.
    bit      m_full;
    int      m_data;
    bit      m_src;
    bit      m_last;
    bit      m_r0;
    bit      m_r1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_full = 0;
        m_data = 0;
        m_src  = 0;
        m_last = 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, m_full});
        check({tag, ".out_data"},  {17'd0, out_data_o},  m_data);
        check({tag, ".out_src"},   {31'd0, out_src_o},   {31'd0, m_src});
    endtask

    task automatic do_reset(input string tag);
        rst_i        = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        out_ready_i  = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();
        check_outputs(tag);
        rst_i = 1'b1;
    endtask

    // One clock: drive inputs, check readies against the rules, clock, check the slot.
    task automatic cycle(input string tag, input bit v0, input int d0,
                         input bit v1, input int d1, input bit ordy);
        bit drain, canl, g;
        req0_valid_i = v0;
        req0_data_i  = W'(d0);
        req1_valid_i = v1;
        req1_data_i  = W'(d1);
        out_ready_i  = ordy;
        #1;
        drain = m_full && ordy;
        canl  = !m_full || drain;
        if (v0 && v1) g = !m_last;
        else          g = v1;
        m_r0 = canl && v0 && !g;
        m_r1 = canl && v1 && g;
        check({tag, ".req0_ready"}, {31'd0, req0_ready_o}, {31'd0, m_r0});
        check({tag, ".req1_ready"}, {31'd0, req1_ready_o}, {31'd0, m_r1});
        @(posedge clk_i);
        if (m_r0 || m_r1) begin
            m_data = g ? (d1 & 32'h7fff) : (d0 & 32'h7fff);
            m_src  = g;
            m_last = g;
            m_full = 1;
        end else if (drain) begin
            m_full = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    bit p0, p1;
    int q0, q1;

    initial begin
        rst_i        = 1'b1;
        req0_valid_i = 1'b0;
        req0_data_i  = '0;
        req1_valid_i = 1'b0;
        req1_data_i  = '0;
        out_ready_i  = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;

        // Reset then idle
        do_reset("reset");
        cycle("idle", 0, 0, 0, 0, 0);

        // Lone req0
        cycle("req0_only", 1, 37, 0, 0, 1);
        check("req0_only.data37", {17'd0, out_data_o}, 37);

        // Contention alternates starting with req0 after reset
        do_reset("reset2");
        for (int i = 0; i < 4; i++) begin
            cycle("contend", 1, 39, 1, 53, 1);
            check("contend.alt_src", {31'd0, out_src_o}, i % 2);
        end

        // Backpressure holds the entry and blocks req1
        do_reset("reset3");
        cycle("bp_load", 1, 144, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", 0, 0, 1, 120, 0);
            check("bp_hold.data144", {17'd0, out_data_o}, 144);
        end
        cycle("bp_release", 0, 0, 1, 120, 1);
        check("bp_release.data120", {17'd0, out_data_o}, 120);

        // Lone req1 with last=1 still wins
        do_reset("reset4");
        cycle("req1_lone_a", 0, 0, 1, 17, 1);
        cycle("req1_lone_b", 0, 0, 1, 17, 1);

        // Reset while full discards the entry and restores req0 priority
        do_reset("reset5");
        cycle("fill53", 0, 0, 1, 53, 0);
        do_reset("reset_full");
        cycle("post_reset_contend", 1, 5, 1, 6, 1);
        check("post_reset.src0", {31'd0, out_src_o}, 0);

        // Randomized traffic: sources hold valid/data until accepted
        p0 = 0;
        p1 = 0;
        q0 = 0;
        q1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (($urandom % 60) == 0) begin
                do_reset("rand_reset");
                p0 = 0;
                p1 = 0;
            end
            if (!p0 && ($urandom % 3) != 0) begin
                p0 = 1;
                q0 = int'($urandom_range(0, 32767));
            end
            if (!p1 && ($urandom % 3) != 0) begin
                p1 = 1;
                q1 = int'($urandom_range(0, 32767));
            end
            cycle("rand", p0, q0, p1, q1, ($urandom % 4) != 0);
            if (m_r0) p0 = 0;
            if (m_r1) p1 = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
